// File: rtl/peripheral_operand_entry.sv
// ---------------------------------------------------------------------------
// peripheral_deco7seg
// Purpose : hex nibble to seven-segment decoder. Segment order is
//           {g,f,e,d,c,b,a} and a segment is lit when its bit is 1.
// Ports   : i_nibble  - value to show
//           i_letter  - 1 = letter digit: only A..F are drawn, 0..9 are blank
//           o_seg     - segment drive
// ---------------------------------------------------------------------------
module peripheral_deco7seg (
    input  logic [3:0] i_nibble,
    input  logic       i_letter,
    output logic [6:0] o_seg
);

    // Plain hex glyphs. A letter digit only carries mode letters, so a
    // numeric code on it is shown blank rather than as a misleading digit.
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
        if (i_letter && (i_nibble < 4'hA)) begin
            o_seg = 7'h00;
        end
    end

endmodule

// ---------------------------------------------------------------------------
// peripheral_operand_entry
// Purpose : byte-by-byte entry of NUM_OPS operands from an 8-bit switch bank
//           using debounced-by-sync enter/back buttons, plus a display mode
//           that pages through the bytes of a result word.
// Ports   : clk, reset (async, active-high)
//           enter, back     - raw buttons, asynchronous to clk
//           loaddata        - level: 1 = entry mode, 0 = result display
//           inputdata[7:0]  - switch byte
//           dataR           - result word to display
//           operands        - operand k at [k*DATA_W +: DATA_W]
//           inputdata_ready - all operands captured
//           disp3..disp0    - seven-segment digits (disp3 is the mode letter)
// ---------------------------------------------------------------------------
module peripheral_operand_entry #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic                      back,
    input  logic                      loaddata,
    input  logic [7:0]                inputdata,
    input  logic [DATA_W-1:0]         dataR,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      inputdata_ready,
    output logic [6:0]                disp3,
    output logic [6:0]                disp2,
    output logic [6:0]                disp1,
    output logic [6:0]                disp0
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OIDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {LOAD, READY, SHOW} state_t;

    // Bit 0 = enter, bit 1 = back, bit 2 = loaddata.
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [2:0] r_prev;

    state_t                    r_state;
    logic [OIDX_W-1:0]         r_oidx;
    logic [BIDX_W-1:0]         r_bidx;
    logic [BIDX_W-1:0]         r_ridx;
    logic [NUM_OPS*DATA_W-1:0] r_operands;
    logic                      r_ready;

    logic       w_enterOnly;
    logic       w_backOnly;
    logic       w_loadRise;
    logic       w_loadFall;
    logic [3:0] w_nib3;
    logic [3:0] w_nib2;
    logic [7:0] w_byte;

    // Two-flop synchroniser per input, plus a third flop holding the previous
    // synchronised level so each press yields a single one-cycle pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= {loaddata, back, enter};
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Simultaneous enter and back is treated as an ambiguous press and dropped.
    assign w_enterOnly = (r_sync[0] & ~r_prev[0]) & ~(r_sync[1] & ~r_prev[1]);
    assign w_backOnly  = (r_sync[1] & ~r_prev[1]) & ~(r_sync[0] & ~r_prev[0]);
    assign w_loadRise  =  r_sync[2] & ~r_prev[2];
    assign w_loadFall  = ~r_sync[2] &  r_prev[2];

    // Mode control and operand capture. Switch edges take priority over the
    // buttons so a mode change never also consumes a button pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= LOAD;
            r_oidx     <= '0;
            r_bidx     <= '0;
            r_ridx     <= '0;
            r_operands <= '0;
            r_ready    <= 1'b0;
        end else if (w_loadFall) begin
            r_state <= SHOW;
            r_ridx  <= '0;
        end else if (w_loadRise) begin
            r_state <= LOAD;
            r_oidx  <= '0;
            r_bidx  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_enterOnly) begin
                        r_operands[int'(r_oidx)*DATA_W + int'(r_bidx)*8 +: 8] <= inputdata;
                        if (r_bidx == BIDX_W'(BYTES-1)) begin
                            r_bidx <= '0;
                            if (r_oidx == OIDX_W'(NUM_OPS-1)) begin
                                r_state <= READY;
                                r_ready <= 1'b1;
                            end else begin
                                r_oidx <= r_oidx + OIDX_W'(1);
                            end
                        end else begin
                            r_bidx <= r_bidx + BIDX_W'(1);
                        end
                    end else if (w_backOnly) begin
                        if (r_bidx != '0) begin
                            r_bidx <= r_bidx - BIDX_W'(1);
                        end else if (r_oidx != '0) begin
                            r_oidx <= r_oidx - OIDX_W'(1);
                            r_bidx <= BIDX_W'(BYTES-1);
                        end
                    end
                end
                READY: begin
                end
                SHOW: begin
                    if (w_enterOnly) begin
                        r_ridx <= (r_ridx == BIDX_W'(BYTES-1)) ? '0 : r_ridx + BIDX_W'(1);
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign operands        = r_operands;
    assign inputdata_ready = r_ready;

    // Display content per mode: letter on disp3, byte index on disp2 and the
    // byte itself on disp1:disp0. The result byte is taken live from dataR.
    always_comb begin
        w_nib3 = 4'hA;
        w_nib2 = 4'h0;
        w_byte = 8'h00;
        case (r_state)
            LOAD: begin
                w_nib3 = 4'hA + 4'(r_oidx);
                w_nib2 = 4'(r_bidx);
                w_byte = inputdata;
            end
            READY: begin
                w_nib3 = 4'hC;
                w_nib2 = 4'(BYTES-1);
                w_byte = r_operands[NUM_OPS*DATA_W-8 +: 8];
            end
            SHOW: begin
                w_nib3 = 4'hE;
                w_nib2 = 4'(r_ridx);
                w_byte = dataR[int'(r_ridx)*8 +: 8];
            end
            default: begin
                w_nib3 = 4'hA;
            end
        endcase
    end

    peripheral_deco7seg u_deco3 (.i_nibble(w_nib3),      .i_letter(1'b1), .o_seg(disp3));
    peripheral_deco7seg u_deco2 (.i_nibble(w_nib2),      .i_letter(1'b0), .o_seg(disp2));
    peripheral_deco7seg u_deco1 (.i_nibble(w_byte[7:4]), .i_letter(1'b0), .o_seg(disp1));
    peripheral_deco7seg u_deco0 (.i_nibble(w_byte[3:0]), .i_letter(1'b0), .o_seg(disp0));

endmodule

// File: tb/tb_peripheral_operand_entry.sv
// ---------------------------------------------------------------------------
// tb_peripheral_operand_entry
// Purpose : self-checking bench for peripheral_operand_entry. Instance A uses
//           the default 32-bit / 2-operand configuration, instance B the
//           16-bit / 3-operand configuration. A behavioural model of the entry
//           position (a flat byte counter) predicts instance A.
// ---------------------------------------------------------------------------
module tb_peripheral_operand_entry;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enter, back, loaddata;
    logic [7:0]  inputdata;
    logic [31:0] dataR;
    logic [63:0] operands;
    logic        ready;
    logic [6:0]  disp3, disp2, disp1, disp0;

    logic        enterB, backB, loaddataB;
    logic [7:0]  inputdataB;
    logic [15:0] dataRB;
    logic [47:0] operandsB;
    logic        readyB;
    logic [6:0]  dispB3, dispB2, dispB1, dispB0;

    int nChecks = 0;
    int nFails  = 0;

    // Model of instance A: flat byte position 0..7, mode 0=LOAD 1=READY 2=SHOW.
    logic [7:0] mBytes [8];
    int         mMode, mPos, mRidx;
    logic       mReady, mLoad;

    peripheral_operand_entry #(.DATA_W(32), .NUM_OPS(2)) dutA (
        .clk(clk), .reset(reset), .enter(enter), .back(back), .loaddata(loaddata),
        .inputdata(inputdata), .dataR(dataR), .operands(operands),
        .inputdata_ready(ready), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
    );

    peripheral_operand_entry #(.DATA_W(16), .NUM_OPS(3)) dutB (
        .clk(clk), .reset(reset), .enter(enterB), .back(backB), .loaddata(loaddataB),
        .inputdata(inputdataB), .dataR(dataRB), .operands(operandsB),
        .inputdata_ready(readyB), .disp3(dispB3), .disp2(dispB2), .disp1(dispB1), .disp0(dispB0)
    );

    // Expected glyph, {g,f,e,d,c,b,a}; letter digits blank out 0..9.
    function automatic logic [6:0] glyph(input logic [3:0] n, input logic letter);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        if (letter && n < 4'hA) s = 7'h00;
        return s;
    endfunction

    function automatic logic [63:0] expOps();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = mBytes[k];
        return v;
    endfunction

    function automatic logic [27:0] expDisp();
        logic [3:0] n3, n2;
        logic [7:0] shown;
        if (mMode == 0) begin
            n3 = 4'(10 + mPos / 4); n2 = 4'(mPos % 4); shown = inputdata;
        end else if (mMode == 1) begin
            n3 = 4'hC; n2 = 4'd3; shown = mBytes[7];
        end else begin
            n3 = 4'hE; n2 = 4'(mRidx); shown = dataR[mRidx*8 +: 8];
        end
        return {glyph(n3, 1'b1), glyph(n2, 1'b0), glyph(shown[7:4], 1'b0), glyph(shown[3:0], 1'b0)};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 8; k++) mBytes[k] = 8'h00;
        mMode = 0; mPos = 0; mRidx = 0; mReady = 1'b0; mLoad = 1'b1;
    endtask

    task automatic modelEnter(input logic [7:0] d);
        if (mMode == 0) begin
            mBytes[mPos] = d;
            mPos++;
            if (mPos == 8) begin mMode = 1; mReady = 1'b1; end
        end else if (mMode == 2) begin
            mRidx = (mRidx + 1) % 4;
        end
    endtask

    // Stimulus: each press ends with the button released and the design settled.
    task automatic applyEnter(input logic [7:0] d, input int hold);
        @(negedge clk); inputdata = d; enter = 1'b1;
        repeat (hold) @(negedge clk);
        enter = 1'b0;
        repeat (3) @(negedge clk);
        modelEnter(d);
    endtask

    task automatic applyBack(input int hold);
        @(negedge clk); back = 1'b1;
        repeat (hold) @(negedge clk);
        back = 1'b0;
        repeat (3) @(negedge clk);
        if (mMode == 0 && mPos > 0) mPos--;
    endtask

    task automatic applyBoth();
        @(negedge clk); enter = 1'b1; back = 1'b1;
        repeat (2) @(negedge clk);
        enter = 1'b0; back = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic applyLoad(input logic v);
        @(negedge clk); loaddata = v;
        repeat (4) @(negedge clk);
        if (mLoad && !v) begin mMode = 2; mRidx = 0; end
        if (!mLoad && v) begin mMode = 0; mPos = 0; mReady = 1'b0; end
        mLoad = v;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        modelReset();
        nChecks++;
        if (operands !== 64'h0) begin nFails++; $display("[TB] FAIL reset_operands: got %h want 0", operands); end
        nChecks++;
        if (ready !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ready: got %b want 0", ready); end
        nChecks++;
        if ({disp3, disp2, disp1, disp0} !== expDisp()) begin
            nFails++; $display("[TB] FAIL reset_disp: got %h want %h", {disp3, disp2, disp1, disp0}, expDisp());
        end
        nChecks++;
        if (operandsB !== 48'h0 || readyB !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset_instB: got %h/%b want 0/0", operandsB, readyB);
        end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
        nChecks++;
        if ({disp3, disp2} !== {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)}) begin
            nFails++; $display("[TB] FAIL release_position: got %h want %h", {disp3, disp2}, {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)});
        end
    endtask

    task automatic test_latency();
        @(negedge clk); inputdata = 8'h11; enter = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nChecks++;
        if (operands[7:0] !== 8'h00) begin nFails++; $display("[TB] FAIL latency_early: got %h want 00", operands[7:0]); end
        @(posedge clk); #1;
        nChecks++;
        if (operands[7:0] !== 8'h11) begin nFails++; $display("[TB] FAIL latency_n2: got %h want 11", operands[7:0]); end
        @(negedge clk); enter = 1'b0;
        repeat (3) @(negedge clk);
        modelEnter(8'h11);
    endtask

    task automatic test_full_entry();
        for (int i = 1; i < 7; i++) applyEnter(8'((i + 1) * 17), 2);
        @(negedge clk); inputdata = 8'h88; enter = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nChecks++;
        if (ready !== 1'b0) begin nFails++; $display("[TB] FAIL ready_early: got %b want 0", ready); end
        @(posedge clk); #1;
        nChecks++;
        if (ready !== 1'b1) begin nFails++; $display("[TB] FAIL ready_n2: got %b want 1", ready); end
        @(negedge clk); enter = 1'b0;
        repeat (3) @(negedge clk);
        modelEnter(8'h88);
        nChecks++;
        if (operands !== 64'h88776655_44332211) begin
            nFails++; $display("[TB] FAIL full_entry_operands: got %h want 8877665544332211", operands);
        end
        nChecks++;
        if ({disp3, disp2, disp1, disp0} !== expDisp()) begin
            nFails++; $display("[TB] FAIL ready_disp: got %h want %h", {disp3, disp2, disp1, disp0}, expDisp());
        end
        applyEnter(8'hFF, 2);
        applyBack(2);
        nChecks++;
        if (operands !== 64'h88776655_44332211 || ready !== 1'b1) begin
            nFails++; $display("[TB] FAIL ready_ignores_buttons: got %h/%b want 8877665544332211/1", operands, ready);
        end
    endtask

    task automatic test_show();
        logic [7:0] seq [4];
        seq[0] = 8'hBE; seq[1] = 8'hAD; seq[2] = 8'hDE; seq[3] = 8'hEF;
        dataR = 32'hDEADBEEF;
        applyLoad(1'b0);
        nChecks++;
        if ({disp3, disp2, disp1, disp0} !== {glyph(4'hE, 1'b1), glyph(4'h0, 1'b0), glyph(4'hE, 1'b0), glyph(4'hF, 1'b0)}) begin
            nFails++; $display("[TB] FAIL show_first: got %h want E/0/EF", {disp3, disp2, disp1, disp0});
        end
        nChecks++;
        if (ready !== 1'b1) begin nFails++; $display("[TB] FAIL show_ready: got %b want 1", ready); end
        for (int i = 0; i < 4; i++) begin
            applyEnter(8'h00, 1);
            nChecks++;
            if ({disp1, disp0} !== {glyph(seq[i][7:4], 1'b0), glyph(seq[i][3:0], 1'b0)}) begin
                nFails++; $display("[TB] FAIL show_page%0d: got %h want byte %h", i, {disp1, disp0}, seq[i]);
            end
        end
        applyBack(1);
        nChecks++;
        if ({disp3, disp2, disp1, disp0} !== expDisp()) begin
            nFails++; $display("[TB] FAIL show_back_ignored: got %h want %h", {disp3, disp2, disp1, disp0}, expDisp());
        end
    endtask

    task automatic test_back();
        applyLoad(1'b1);
        nChecks++;
        if (ready !== 1'b0 || operands !== 64'h88776655_44332211) begin
            nFails++; $display("[TB] FAIL reload_retains: got %h/%b want 8877665544332211/0", operands, ready);
        end
        applyEnter(8'h11, 1); applyEnter(8'h22, 1); applyBack(1); applyEnter(8'h33, 1);
        nChecks++;
        if (operands[15:0] !== 16'h3311) begin nFails++; $display("[TB] FAIL back_overwrite: got %h want 3311", operands[15:0]); end
        applyBack(1); applyBack(1); applyBack(3);
        nChecks++;
        if ({disp3, disp2} !== {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)}) begin
            nFails++; $display("[TB] FAIL back_at_origin: got %h want %h", {disp3, disp2}, {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)});
        end
    endtask

    task automatic test_hold_and_both();
        applyEnter(8'h5C, 50);
        nChecks++;
        if (operands !== expOps() || disp2 !== glyph(4'h1, 1'b0)) begin
            nFails++; $display("[TB] FAIL hold_single_capture: got %h/%h want %h/%h", operands, disp2, expOps(), glyph(4'h1, 1'b0));
        end
        applyBoth();
        nChecks++;
        if (operands !== expOps() || {disp3, disp2, disp1, disp0} !== expDisp()) begin
            nFails++; $display("[TB] FAIL both_ignored: got %h/%h want %h/%h", operands, {disp3, disp2, disp1, disp0}, expOps(), expDisp());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) applyEnter(8'($urandom_range(1, 255)), 1);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
        repeat (4) @(negedge clk);
        nChecks++;
        if (operands !== 64'h0 || ready !== 1'b0) begin
            nFails++; $display("[TB] FAIL reset_mid_state: got %h/%b want 0/0", operands, ready);
        end
        nChecks++;
        if ({disp3, disp2} !== {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)}) begin
            nFails++; $display("[TB] FAIL reset_mid_disp: got %h want %h", {disp3, disp2}, {glyph(4'hA, 1'b1), glyph(4'h0, 1'b0)});
        end
    endtask

    task automatic test_sweep();
        logic [47:0] want;
        logic [7:0]  d;
        want = '0;
        for (int i = 0; i < 6; i++) begin
            nChecks++;
            if ({dispB3, dispB2} !== {glyph(4'(10 + i / 2), 1'b1), glyph(4'(i % 2), 1'b0)}) begin
                nFails++; $display("[TB] FAIL sweep_pos%0d: got %h want %h", i, {dispB3, dispB2}, {glyph(4'(10 + i / 2), 1'b1), glyph(4'(i % 2), 1'b0)});
            end
            d = 8'($urandom);
            want[i*8 +: 8] = d;
            @(negedge clk); inputdataB = d; enterB = 1'b1;
            repeat (2) @(negedge clk);
            enterB = 1'b0;
            repeat (3) @(negedge clk);
        end
        nChecks++;
        if (readyB !== 1'b1 || operandsB !== want) begin
            nFails++; $display("[TB] FAIL sweep_ready: got %h/%b want %h/1", operandsB, readyB, want);
        end
        nChecks++;
        if ({dispB3, dispB2} !== {glyph(4'hC, 1'b1), glyph(4'h1, 1'b0)}) begin
            nFails++; $display("[TB] FAIL sweep_ready_disp: got %h want %h", {dispB3, dispB2}, {glyph(4'hC, 1'b1), glyph(4'h1, 1'b0)});
        end
    endtask

    task automatic test_random();
        int r;
        dataR = $urandom;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      applyEnter(8'($urandom), $urandom_range(1, 4));
            else if (r < 75) applyBack($urandom_range(1, 3));
            else if (r < 90) applyBoth();
            else             applyLoad(~mLoad);
            nChecks++;
            if (operands !== expOps() || ready !== mReady || {disp3, disp2, disp1, disp0} !== expDisp()) begin
                nFails++;
                $display("[TB] FAIL random_step%0d: got %h/%b/%h want %h/%b/%h", i, operands, ready,
                         {disp3, disp2, disp1, disp0}, expOps(), mReady, expDisp());
            end
        end
    endtask

    initial begin
        reset = 1'b1; enter = 1'b0; back = 1'b0; loaddata = 1'b1; inputdata = 8'h5A; dataR = '0;
        enterB = 1'b0; backB = 1'b0; loaddataB = 1'b1; inputdataB = 8'h00; dataRB = 16'h1234;
        modelReset();
        test_reset();
        test_latency();
        test_full_entry();
        test_show();
        test_back();
        test_hold_and_both();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
